// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding and fetch constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: seqState_t, DEFAULT_WIDTH, PC_INCR (bytes per instruction), LINK_REG (return-address register index).
package pc_sequencer_pkg;

    // Default address/data width of the sequencer datapath.
    localparam int DEFAULT_WIDTH = 16;

    // Instructions are 16-bit, so sequential fetch advances by two bytes.
    localparam int unsigned PC_INCR = 2;

    // Register that receives the return address on JAL/JALR.
    localparam int unsigned LINK_REG = 7;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        WAIT     = 2'd1,
        REDIRECT = 2'd2,
        HALTED   = 2'd3
    } seqState_t;

endpackage : pc_sequencer_pkg

// File: rtl/pc_sequencer_if.sv
// Decode/fetch bus between the PC sequencer (master) and decode + instruction memory (slave).
// Latency: n/a (wires only).
// Backpressure: memReady from the slave stalls the fetch request; fetchReq is never withdrawn.
// Signals: jump request (jumpValid, enJMP, enJR, enJAL, instrPc, disp, rsVal, imm),
//          fetch (fetchReq, fetchAddr, memReady), redirect (flush, linkWrEn, linkData).
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    // Decode-stage jump request
    logic             jumpValid;
    logic             enJMP;
    logic             enJR;
    logic             enJAL;
    logic [WIDTH-1:0] instrPc;
    logic [WIDTH-1:0] disp;
    logic [WIDTH-1:0] rsVal;
    logic [WIDTH-1:0] imm;

    // Instruction fetch
    logic             fetchReq;
    logic [WIDTH-1:0] fetchAddr;
    logic             memReady;

    // Pipeline redirect and link write-back
    logic             flush;
    logic             linkWrEn;
    logic [WIDTH-1:0] linkData;

    modport master (
        input  jumpValid, enJMP, enJR, enJAL, instrPc, disp, rsVal, imm, memReady,
        output fetchReq, fetchAddr, flush, linkWrEn, linkData
    );

    modport slave (
        output jumpValid, enJMP, enJR, enJAL, instrPc, disp, rsVal, imm, memReady,
        input  fetchReq, fetchAddr, flush, linkWrEn, linkData
    );

endinterface : pc_sequencer_if

// File: rtl/pc_sequencer_jump_target_calc.sv
// Jump target and return-address arithmetic for the PC sequencer.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
// Ports: enJR selects register form (rsVal+imm) over PC-relative (instrPc+2+disp); target, linkData (instrPc+2);
//        targetOdd only when JUMP_ALIGN_CHECK_EN is defined, otherwise target bit0 is forced to 0.
module jump_target_calc
    import pc_sequencer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             enJR,
    input  logic [WIDTH-1:0] instrPc,
    input  logic [WIDTH-1:0] disp,
    input  logic [WIDTH-1:0] rsVal,
    input  logic [WIDTH-1:0] imm,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] linkData
`ifdef JUMP_ALIGN_CHECK_EN
    ,
    output logic             targetOdd
`endif
);

    logic [WIDTH-1:0] seqNext;
    logic [WIDTH-1:0] rawTarget;

    // Address of the instruction after the one being decoded; both the
    // PC-relative base and the return address. Wraps modulo 2^WIDTH.
    assign seqNext   = instrPc + WIDTH'(PC_INCR);
    assign rawTarget = enJR ? (rsVal + imm) : (seqNext + disp);
    assign linkData  = seqNext;

`ifdef JUMP_ALIGN_CHECK_EN
    assign target    = rawTarget;
    assign targetOdd = rawTarget[0];
`else
    // Instructions are halfword aligned; an odd target silently rounds down.
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(1);
    assign target = rawTarget & ALIGN_MASK;
`endif

endmodule : jump_target_calc

// File: rtl/pc_sequencer.sv
// Instruction fetch PC sequencer: sequential fetch, J/JAL/JR/JALR redirect with link write, halt.
// Latency: fetchAddr advances the cycle after memReady; a jump taken at cycle N flushes at N+1, fetches target at N+2.
// Backpressure: memReady=0 holds fetchReq/fetchAddr (WAIT); jumps and halt wait for the outstanding fetch to finish.
// Ports: clk, rst (sync, active-high), bus (pc_sequencer_if.master), halt in, busy out;
//        misalign out only when JUMP_ALIGN_CHECK_EN is defined (odd target reported instead of redirecting).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int               WIDTH    = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master bus,
    input  logic           halt,
    output logic           busy
`ifdef JUMP_ALIGN_CHECK_EN
    ,
    output logic           misalign
`endif
);

    seqState_t        state;
    seqState_t        stateNext;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcNext;

    // Jump taken but waiting for the in-flight fetch to complete
    logic             pendValid;
    logic [WIDTH-1:0] pendTarget;
    logic             pendLink;
    logic [WIDTH-1:0] linkReg;

    // Halt seen while a fetch was still outstanding
    logic             haltPend;

    logic [WIDTH-1:0] calcTarget;
    logic [WIDTH-1:0] calcLink;
    logic             jumpOdd;

    logic             seqActive;
    logic             acceptJump;
    logic             takeJump;

    logic             fetchReqC;
    logic             flushC;
    logic             linkWrEnC;
    logic             busyC;

    jump_target_calc #(
        .WIDTH (WIDTH)
    ) uTargetCalc (
        .enJR      (bus.enJR),
        .instrPc   (bus.instrPc),
        .disp      (bus.disp),
        .rsVal     (bus.rsVal),
        .imm       (bus.imm),
        .target    (calcTarget),
        .linkData  (calcLink)
`ifdef JUMP_ALIGN_CHECK_EN
        ,
        .targetOdd (jumpOdd)
`endif
    );

`ifndef JUMP_ALIGN_CHECK_EN
    assign jumpOdd = 1'b0;
`endif

    // Jumps are only taken while fetching; exactly one jump kind must be
    // enabled, and a same-cycle halt wins over the jump.
    assign seqActive  = (state == FETCH) || (state == WAIT);
    assign acceptJump = seqActive && bus.jumpValid && (bus.enJMP ^ bus.enJR) && !halt;
    // A misaligned target is reported, not followed.
    assign takeJump   = acceptJump && !jumpOdd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        pcNext    = pc;
        fetchReqC = 1'b0;
        flushC    = 1'b0;
        linkWrEnC = 1'b0;
        busyC     = 1'b1;

        case (state)
            FETCH, WAIT: begin
                fetchReqC = 1'b1;
                if (bus.memReady) begin
                    pcNext = pc + WIDTH'(PC_INCR);
                    if (halt || haltPend) begin
                        stateNext = HALTED;
                    end else if (takeJump || pendValid) begin
                        stateNext = REDIRECT;
                    end else begin
                        stateNext = FETCH;
                    end
                end else begin
                    stateNext = WAIT;
                end
            end
            REDIRECT: begin
                flushC    = 1'b1;
                linkWrEnC = pendLink;
                pcNext    = pendTarget;
                stateNext = FETCH;
            end
            HALTED: begin
                busyC = 1'b0;
            end
            default: begin
                stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc         <= RESET_PC;
            pendValid  <= 1'b0;
            pendTarget <= '0;
            pendLink   <= 1'b0;
            linkReg    <= '0;
            haltPend   <= 1'b0;
        end else begin
            pc <= pcNext;

            // The target is captured at acceptance so decode may move on
            // while the outstanding fetch is still stalled.
            if (takeJump) begin
                pendValid  <= 1'b1;
                pendTarget <= calcTarget;
                pendLink   <= bus.enJAL;
                if (bus.enJAL) begin
                    linkReg <= calcLink;
                end
            end else if (state == REDIRECT) begin
                pendValid <= 1'b0;
                pendLink  <= 1'b0;
            end

            if (seqActive && halt && !bus.memReady) begin
                haltPend <= 1'b1;
            end
        end
    end

`ifdef JUMP_ALIGN_CHECK_EN
    logic misalignQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalignQ <= 1'b0;
        end else begin
            misalignQ <= acceptJump && jumpOdd;
        end
    end

    assign misalign = misalignQ && !rst;
`endif

    // Outputs are forced quiet for the whole reset cycle, not just after
    // the first edge.
    assign bus.fetchReq  = fetchReqC && !rst;
    assign bus.fetchAddr = pc;
    assign bus.flush     = flushC && !rst;
    assign bus.linkWrEn  = linkWrEnC && !rst;
    assign bus.linkData  = rst ? '0 : linkReg;
    assign busy          = busyC && !rst;

endmodule : pc_sequencer
